// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises host words MSB-first onto ccff_head,
// CRCs the stream on load, and CRCs ccff_tail on a verify re-shift for readback.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       ref_crc
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // FETCH | cfg_ready high, waiting for the next word
  // SHIFT | one bit of the current word per cycle
  // FIN   | last bit shifting out; latch CRC result
  // DONE  | result held until the next start
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    FIN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WORD_END  = WB_W'(WORD_W);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_sr;
  logic [WB_W-1:0]   wcnt;
  logic [WB_W-1:0]   wcnt_inc;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [15:0]       crc;
  logic [15:0]       crc_upd;
  logic              verify_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign cnt_inc  = bit_cnt + 1'b1;
  assign wcnt_inc = wcnt + 1'b1;

  // The chain consumes a bit on the edge after shift_en is high, so the CRC
  // steps on that same edge; the tail bit seen then is the one leaving the chain.
  assign crc_upd = shift_en ? crc_step(crc, verify_q ? ccff_tail : ccff_head) : crc;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_inc == CHAIN_END)     state_d = FIN;
        else if (wcnt_inc == WORD_END) state_d = FETCH;
      end
      FIN:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      word_sr   <= '0;
      wcnt      <= '0;
      bit_cnt   <= '0;
      crc       <= 16'hFFFF;
      ref_crc   <= 16'hFFFF;
      verify_q  <= 1'b0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      crc       <= crc_upd;
      shift_en  <= 1'b0;
      ccff_head <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            verify_q <= verify;
            bit_cnt  <= '0;
            crc      <= 16'hFFFF;
            done     <= 1'b0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            word_sr <= cfg_data;
            wcnt    <= '0;
          end
        end
        SHIFT: begin
          ccff_head <= word_sr[WORD_W-1];
          shift_en  <= 1'b1;
          word_sr   <= word_sr << 1;
          bit_cnt   <= cnt_inc;
          wcnt      <= wcnt_inc;
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (verify_q) begin
            pass <= (crc_upd == ref_crc);
          end else begin
            ref_crc <= crc_upd;
            pass    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a 20-flop loopback chain on
// ccff_head/ccff_tail and a bit-serial CRC-16-CCITT reference.
module tb_ccff_bitstream_loader;

  logic        prog_clk;
  logic        pReset;
  logic        start;
  logic        verify;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        ccff_head;
  logic        shift_en;
  logic        ccff_tail;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] ref_crc;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .verify   (verify),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .shift_en (shift_en),
    .ccff_tail(ccff_tail),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .ref_crc  (ref_crc)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Chain model: first bit in ends up at chain[19] after 20 shifts.
  logic [19:0] chain = '0;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[18:0], ccff_head};
  assign ccff_tail = chain[19];

  // Head-side capture of what the DUT shifts in.
  logic [19:0] cap;
  int          n_shift;
  always @(posedge prog_clk) begin
    if (shift_en) begin
      cap     = {cap[18:0], ccff_head};
      n_shift = n_shift + 1;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [19:0] STREAM     = 20'hA53CF;
  localparam logic [19:0] STREAM_MOD = 20'hA53DF;

  function automatic logic [15:0] crc_model(input logic [19:0] s);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 19; i >= 0; i--) begin
      fb = c[15] ^ s[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Called at a negedge; returns at a negedge after the word was accepted.
  task automatic feed(input logic [7:0] w);
    bit got;
    got       = 1'b0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    if (!got) chk("handshake_timeout", 32'(got), 32'd1);
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic feed_stalled(input logic [7:0] w);
    bit got;
    got       = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    if (!got) chk("stall_ready_timeout", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      chk("stall_shift_en", 32'(shift_en), 32'd0);
    end
    feed(w);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    if (!got) chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic pulse_start(input logic v);
    start  = 1'b1;
    verify = v;
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
  endtask

  task automatic run_pass(input logic v, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input bit stall);
    n_shift = 0;
    cap     = '0;
    pulse_start(v);
    feed(w0);
    if (stall) feed_stalled(w1);
    else       feed(w1);
    feed(w2);
    wait_done();
  endtask

  logic [15:0] gold;
  bit          got9;

  initial begin
    gold      = crc_model(STREAM);
    pReset    = 1'b1;
    start     = 1'b0;
    verify    = 1'b0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    n_shift   = 0;
    cap       = '0;
    repeat (3) @(negedge prog_clk);

    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_pass",      32'(pass),      32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_shift_en",  32'(shift_en),  32'd0);
    chk("rst_head",      32'(ccff_head), 32'd0);
    chk("rst_ref_crc",   32'(ref_crc),   32'h0000_FFFF);
    pReset = 1'b0;
    @(negedge prog_clk);

    // Load pass
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 1'b0);
    chk("load_bits",    32'(cap),     32'(STREAM));
    chk("load_nshift",  32'(n_shift), 32'd20);
    chk("load_done",    32'(done),    32'd1);
    chk("load_busy",    32'(busy),    32'd0);
    chk("load_pass",    32'(pass),    32'd0);
    chk("load_ref_crc", 32'(ref_crc), 32'(gold));
    chk("load_chain",   32'(chain),   32'(STREAM));

    // Host words outside FETCH are ignored
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    repeat (3) begin
      @(negedge prog_clk);
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    @(negedge prog_clk);

    // Good verify
    run_pass(1'b1, 8'hA5, 8'h3C, 8'hF0, 1'b0);
    chk("ver1_pass",    32'(pass),    32'd1);
    chk("ver1_nshift",  32'(n_shift), 32'd20);
    chk("ver1_ref_crc", 32'(ref_crc), 32'(gold));

    // Verify with a modified stream: tail still returns the loaded bits
    run_pass(1'b1, 8'hA5, 8'h3D, 8'hF0, 1'b0);
    chk("ver2_pass",    32'(pass),    32'd1);
    chk("ver2_bits",    32'(cap),     32'(STREAM_MOD));
    chk("ver2_ref_crc", 32'(ref_crc), 32'(gold));

    // Chain now holds the modified stream
    run_pass(1'b1, 8'hA5, 8'h3C, 8'hF0, 1'b0);
    chk("ver3_pass",    32'(pass),    32'd0);
    chk("ver3_done",    32'(done),    32'd1);
    chk("ver3_ref_crc", 32'(ref_crc), 32'(gold));

    // Host stall between words 1 and 2
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hF0, 1'b1);
    chk("stall_bits",    32'(cap),     32'(STREAM));
    chk("stall_nshift",  32'(n_shift), 32'd20);
    chk("stall_ref_crc", 32'(ref_crc), 32'(gold));

    // Last word 0xFF: only its top 4 bits are used
    run_pass(1'b0, 8'hA5, 8'h3C, 8'hFF, 1'b0);
    chk("ff_bits",    32'(cap),     32'(STREAM));
    chk("ff_nshift",  32'(n_shift), 32'd20);
    chk("ff_ref_crc", 32'(ref_crc), 32'(gold));

    // Reset at bit 9 of a load
    n_shift = 0;
    cap     = '0;
    pulse_start(1'b0);
    feed(8'hA5);
    feed(8'h3C);
    got9 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_shift >= 9) begin
        got9 = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    if (!got9) chk("bit9_timeout", 32'(got9), 32'd1);
    #2 pReset = 1'b1;
    #1;
    chk("arst_shift_en",  32'(shift_en),  32'd0);
    chk("arst_head",      32'(ccff_head), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_done",      32'(done),      32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("arst_ref_crc",   32'(ref_crc),   32'h0000_FFFF);
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);

    // Fresh load after reset, with a start pulse while busy that must be ignored
    n_shift = 0;
    cap     = '0;
    pulse_start(1'b0);
    feed(8'hA5);
    start  = 1'b1;
    verify = 1'b1;
    @(negedge prog_clk);
    start  = 1'b0;
    verify = 1'b0;
    feed(8'h3C);
    feed(8'hF0);
    wait_done();
    chk("reload_bits",    32'(cap),     32'(STREAM));
    chk("reload_nshift",  32'(n_shift), 32'd20);
    chk("reload_pass",    32'(pass),    32'd0);
    chk("reload_ref_crc", 32'(ref_crc), 32'(gold));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
